// File: rtl/nlfsr_pkg.sv
// Shared types and helpers for the NLFSR tap-pair sequencer and its result FIFO.
package nlfsr_pkg;

  localparam int unsigned COEF_W = 8;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned TAPS_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD1,
    S_LOAD2,
    S_RUN,
    S_PUSH,
    S_NEXT,
    S_DONE
  } seq_state_e;

  // Result word layout: {3'b0, b, 3'b0, a}
  function automatic logic [TAPS_W-1:0] pack_taps(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
    return {3'b000, b, 3'b000, a};
  endfunction

  function automatic int unsigned pair_count(input int unsigned size);
    return ((size - 1) * (size - 2)) / 2;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/nlfsr_tap_sequencer_if.sv
// Result stream from the tap sequencer: packed (b,a) tap pairs with valid/ready handshake.
interface nlfsr_tap_sequencer_if;
  import nlfsr_pkg::*;

  logic              res_valid;
  logic              res_ready;
  logic [TAPS_W-1:0] res_taps;

  modport master (output res_valid, output res_taps, input res_ready);
  modport slave  (input res_valid, input res_taps, output res_ready);

endinterface

// File: rtl/nlfsr_result_fifo.sv
// Synchronous FIFO whose read data is a register holding the current head entry.
module nlfsr_result_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_nxt = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
      // Head register: bypass the write when the new head is the slot being written now.
      if (do_push && (rd_ptr_nxt == wr_ptr)) rd_data <= wr_data;
      else                                   rd_data <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/nlfsr_tap_sequencer.sv
// Sweeps every nonlinear tap pair (a,b) through one NLFSR period tester and
// queues the maximal-period hits in a small FIFO for a valid/ready consumer.
module nlfsr_tap_sequencer
  import nlfsr_pkg::*;
#(
  parameter int unsigned SIZE       = 24,
  parameter int unsigned BYTES      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [35:0] WATCHDOG   = (36'd1 << SIZE) + 36'd7
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic [BYTES*8-1:1]    lin_coef,
  output logic                  tst_res,
  output logic                  tst_ena,
  output logic                  take_coef,
  output logic [COEF_W-1:0]     coef,
  output logic [BYTES*8-1:1]    co_buf_lin,
  input  logic                  tst_ready,
  input  logic                  tst_found,
  input  logic                  tst_failure,
  nlfsr_tap_sequencer_if.master result,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           hit_count,
  output logic [15:0]           timeout_count
);

  localparam logic [IDX_W-1:0] A_LAST = IDX_W'(SIZE - 2);
  localparam logic [IDX_W-1:0] B_LAST = IDX_W'(SIZE - 1);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  a_q, a_d, b_q, b_d;
  logic [35:0]       wait_q, wait_d;
  logic [15:0]       hit_q, hit_d, tmo_q, tmo_d;
  logic              load_lin;
  logic              fifo_push, fifo_full, fifo_empty;
  logic [TAPS_W-1:0] fifo_rd_data;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    wait_d    = wait_q;
    hit_d     = hit_q;
    tmo_d     = tmo_q;
    load_lin  = 1'b0;
    fifo_push = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_CLEAR;
          a_d      = IDX_W'(1);
          b_d      = IDX_W'(2);
          hit_d    = '0;
          tmo_d    = '0;
          load_lin = 1'b1;
        end
      end
      S_CLEAR: state_d = S_LOAD1;
      S_LOAD1: state_d = S_LOAD2;
      S_LOAD2: begin
        state_d = S_RUN;
        wait_d  = 36'd1;
      end
      S_RUN: begin
        // wait_q counts RUN cycles including the current one; found beats failure.
        wait_d = wait_q + 36'd1;
        if (tst_found) begin
          state_d = S_PUSH;
        end else if (tst_failure) begin
          state_d = S_NEXT;
        end else if ((wait_q == WATCHDOG) || ((wait_q == 36'd1) && !tst_ready)) begin
          state_d = S_NEXT;
          tmo_d   = sat_inc16(tmo_q);
        end
      end
      S_PUSH: begin
        if (!fifo_full) begin
          fifo_push = 1'b1;
          hit_d     = sat_inc16(hit_q);
          state_d   = S_NEXT;
        end
      end
      S_NEXT: begin
        if (b_q < B_LAST) begin
          b_d     = b_q + IDX_W'(1);
          state_d = S_CLEAR;
        end else if (a_q < A_LAST) begin
          a_d     = a_q + IDX_W'(1);
          b_d     = a_q + IDX_W'(2);
          state_d = S_CLEAR;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tester controls are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= S_IDLE;
      a_q        <= IDX_W'(1);
      b_q        <= IDX_W'(2);
      wait_q     <= '0;
      hit_q      <= '0;
      tmo_q      <= '0;
      co_buf_lin <= '0;
      tst_res    <= 1'b1;
      tst_ena    <= 1'b0;
      take_coef  <= 1'b0;
      coef       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      wait_q    <= wait_d;
      hit_q     <= hit_d;
      tmo_q     <= tmo_d;
      if (load_lin) co_buf_lin <= lin_coef;
      tst_res   <= state_d inside {S_IDLE, S_CLEAR, S_DONE};
      tst_ena   <= state_d inside {S_LOAD1, S_LOAD2, S_RUN};
      take_coef <= state_d inside {S_LOAD1, S_LOAD2};
      if (state_d == S_LOAD1)      coef <= {{(COEF_W-IDX_W){1'b0}}, a_d};
      else if (state_d == S_LOAD2) coef <= {{(COEF_W-IDX_W){1'b0}}, b_d};
      else                         coef <= '0;
      busy      <= !(state_d inside {S_IDLE, S_DONE});
      done      <= (state_d == S_DONE);
    end
  end

  nlfsr_result_fifo #(
    .WIDTH (TAPS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .res     (res),
    .push    (fifo_push),
    .wr_data (pack_taps(a_q, b_q)),
    .pop     (result.res_ready),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .rd_data (fifo_rd_data)
  );

  assign result.res_valid = !fifo_empty;
  assign result.res_taps  = fifo_rd_data;
  assign hit_count        = hit_q;
  assign timeout_count    = tmo_q;

endmodule

// File: tb/tb_nlfsr_tap_sequencer.sv
// Scoreboard bench for nlfsr_tap_sequencer (SIZE=4, FIFO_DEPTH=2, WATCHDOG=20) with a behavioural tester.
module tb_nlfsr_tap_sequencer;

  localparam int SZ = 4;
  localparam int WD = 20;
  localparam int O_FAIL  = 0;
  localparam int O_FOUND = 1;
  localparam int O_BOTH  = 2;
  localparam int O_NONE  = 3;
  localparam int O_NORDY = 4;

  logic        clk;
  logic        res;
  logic        start;
  logic [31:1] lin_coef;
  logic        tst_res, tst_ena, take_coef;
  logic [7:0]  coef;
  logic [31:1] co_buf_lin;
  logic        tst_ready, tst_found, tst_failure;
  logic        busy, done;
  logic [15:0] hit_count, timeout_count;

  nlfsr_tap_sequencer_if rif ();

  nlfsr_tap_sequencer #(
    .SIZE       (SZ),
    .BYTES      (4),
    .FIFO_DEPTH (2),
    .WATCHDOG   (36'd20)
  ) dut (
    .clk           (clk),
    .res           (res),
    .start         (start),
    .lin_coef      (lin_coef),
    .tst_res       (tst_res),
    .tst_ena       (tst_ena),
    .take_coef     (take_coef),
    .coef          (coef),
    .co_buf_lin    (co_buf_lin),
    .tst_ready     (tst_ready),
    .tst_found     (tst_found),
    .tst_failure   (tst_failure),
    .result        (rif),
    .busy          (busy),
    .done          (done),
    .hit_count     (hit_count),
    .timeout_count (timeout_count)
  );

  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;
  int outc [SZ][SZ];
  int dly  [SZ][SZ];
  int exp_hits, exp_tmo;
  logic [15:0] exp_q[$];
  logic [15:0] cand_q[$];
  int          exp_run_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural tester: outcome and verdict delay are looked up per loaded (a,b) pair.
  initial begin : tester
    logic [7:0] cap_a, cap_b;
    bit got_a;
    int cur, run_n;
    logic n_rdy, n_fnd, n_fail;
    got_a = 0; cur = O_NONE; run_n = 0; cap_a = '0; cap_b = '0;
    tst_ready = 1'b0; tst_found = 1'b0; tst_failure = 1'b0;
    forever begin
      @(negedge clk);
      n_rdy = tst_ready; n_fnd = tst_found; n_fail = tst_failure;
      if (tst_res !== 1'b0) begin
        n_rdy = 1'b0; n_fnd = 1'b0; n_fail = 1'b0; run_n = 0; got_a = 0;
      end else if (take_coef === 1'b1 && !got_a) begin
        cap_a = coef; got_a = 1;
      end else if (take_coef === 1'b1) begin
        cap_b = coef;
        cur   = outc[cap_a[1:0]][cap_b[1:0]];
        n_rdy = (cur != O_NORDY);
      end else if (tst_ena === 1'b1 && !n_fnd && !n_fail) begin
        run_n++;
        if (run_n == dly[cap_a[1:0]][cap_b[1:0]]) begin
          n_fnd  = (cur == O_FOUND) || (cur == O_BOTH);
          n_fail = (cur == O_FAIL)  || (cur == O_BOTH);
        end
      end
      @(posedge clk);
      #1;
      tst_ready = n_rdy; tst_found = n_fnd; tst_failure = n_fail;
    end
  end

  initial begin : rdy_drv
    rif.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rif.res_ready = 1'b0;
        1:       rif.res_ready = 1'b1;
        default: rif.res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : result_mon
    forever begin
      @(negedge clk);
      if (rif.res_valid === 1'b1 && exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: got %04h expected nothing", rif.res_taps);
      end else if (rif.res_valid === 1'b1 && rif.res_ready === 1'b1) begin
        chk("res_taps", 64'(rif.res_taps), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin : cand_mon
    logic [7:0] first;
    bit have;
    have = 0; first = '0;
    forever begin
      @(negedge clk);
      if (take_coef === 1'b1) begin
        if (!have) begin
          first = coef; have = 1;
        end else begin
          have = 0;
          if (cand_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL extra_candidate: got %02h%02h expected none", coef, first);
          end else begin
            chk("candidate_coefs", 64'({coef, first}), 64'(cand_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : run_mon
    int run_len;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (tst_ena === 1'b1 && take_coef === 1'b0) begin
        run_len++;
      end else if (run_len > 0) begin
        // A run that ends in tst_res was aborted, not decided.
        if (tst_res !== 1'b1) begin
          if (exp_run_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL extra_run: got %0d cycles expected none", run_len);
          end else begin
            chk("run_cycles", 64'(run_len), 64'(exp_run_q.pop_front()));
          end
        end
        run_len = 0;
      end
    end
  end

  task automatic set_plan(input int mode);
    for (int a = 0; a < SZ; a++)
      for (int b = 0; b < SZ; b++) begin
        outc[a][b] = (mode < 0) ? int'($urandom_range(0, 4)) : mode;
        dly[a][b]  = int'($urandom_range(1, 8));
      end
  endtask

  task automatic plan_sweep();
    exp_hits = 0;
    exp_tmo  = 0;
    for (int a = 1; a <= SZ - 2; a++)
      for (int b = a + 1; b <= SZ - 1; b++) begin
        cand_q.push_back(16'((b << 8) | a));
        case (outc[a][b])
          O_FOUND, O_BOTH: begin
            exp_q.push_back(16'((b << 8) | a));
            exp_hits++;
            exp_run_q.push_back(dly[a][b] + 1);
          end
          O_FAIL: exp_run_q.push_back(dly[a][b] + 1);
          O_NONE: begin exp_tmo++; exp_run_q.push_back(WD); end
          default: begin exp_tmo++; exp_run_q.push_back(1); end
        endcase
      end
  endtask

  task automatic start_sweep(input logic [31:1] lc);
    plan_sweep();
    lin_coef = lc;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    @(posedge clk);
    #1;
    chk("start_to_take_coef", 64'({take_coef, coef}), 64'({1'b1, 8'd1}));
  endtask

  task automatic wait_done(input logic [31:1] lc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_reached", 64'(done), 64'(1));
    chk("hit_count", 64'(hit_count), 64'(exp_hits));
    chk("timeout_count", 64'(timeout_count), 64'(exp_tmo));
    chk("idle_ctrl_in_done", 64'({busy, tst_res, tst_ena}), 64'({1'b0, 1'b1, 1'b0}));
    chk("co_buf_lin", 64'(co_buf_lin), 64'(lc));
    chk("candidates_left", 64'(cand_q.size()), 64'(0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_mode = 1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("fifo_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin : main
    logic [31:1] lc;
    bit hit;
    res = 1'b1; start = 1'b0; lin_coef = '0;
    set_plan(O_FAIL);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tst_res", 64'(tst_res), 64'(1));
    chk("reset_ctrl", 64'({tst_ena, take_coef, coef}), 64'(0));
    chk("reset_status", 64'({rif.res_valid, busy, done}), 64'(0));
    chk("reset_counters", 64'({hit_count, timeout_count}), 64'(0));
    chk("reset_co_buf_lin", 64'(co_buf_lin), 64'(0));
    res = 1'b0;
    @(posedge clk);
    #1;

    // All verdicts fail
    set_plan(O_FAIL); rdy_mode = 2; lc = 31'($urandom);
    start_sweep(lc); wait_done(lc);

    // Found only for (1,3)
    set_plan(O_FAIL); outc[1][3] = O_FOUND; rdy_mode = 1; lc = 31'($urandom);
    start_sweep(lc); wait_done(lc); drain();

    // Every pair found, consumer stalled: FSM must hang in PUSH at the 3rd hit
    rdy_mode = 0; set_plan(O_FOUND); lc = 31'($urandom);
    start_sweep(lc);
    repeat (150) @(posedge clk);
    #1;
    chk("stall_not_done", 64'({busy, done}), 64'({1'b1, 1'b0}));
    chk("stall_hit_count", 64'(hit_count), 64'(2));
    chk("stall_tester_frozen", 64'({tst_ena, take_coef}), 64'(0));
    chk("stall_res_valid", 64'(rif.res_valid), 64'(1));
    rdy_mode = 1;
    wait_done(lc); drain();

    // No verdict ever: watchdog
    set_plan(O_NONE); lc = 31'($urandom);
    start_sweep(lc); wait_done(lc);

    // found and failure together
    set_plan(O_BOTH); rdy_mode = 2; lc = 31'($urandom);
    start_sweep(lc); wait_done(lc); drain();

    // Tester never ready: immediate timeout
    set_plan(O_NORDY); lc = 31'($urandom);
    start_sweep(lc); wait_done(lc);

    // Abort during RUN of the 2nd candidate
    rdy_mode = 0; set_plan(O_FOUND); lc = 31'($urandom);
    start_sweep(lc);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (take_coef === 1'b1 && coef == 8'd3) hit = 1;
    end
    chk("abort_reached_load2", 64'(hit), 64'(1));
    @(posedge clk);
    #1;
    res = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    chk("abort_tst_res", 64'(tst_res), 64'(1));
    chk("abort_res_valid", 64'(rif.res_valid), 64'(0));
    chk("abort_counters", 64'({hit_count, timeout_count}), 64'(0));
    chk("abort_idle", 64'({busy, done, tst_ena}), 64'(0));
    exp_q.delete(); cand_q.delete(); exp_run_q.delete();
    set_plan(O_FAIL); lc = 31'($urandom);
    start_sweep(lc); wait_done(lc);

    // Random outcomes; first sweep also sees a start pulse while busy
    for (int s = 0; s < 4; s++) begin
      set_plan(-1); rdy_mode = 2; lc = 31'($urandom);
      start_sweep(lc);
      if (s == 0) begin
        repeat (3) @(posedge clk);
        #1;
        lin_coef = ~lc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      wait_done(lc);
    end
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("runs_left", 64'(exp_run_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nlfsr_tap_sequencer.md
# nlfsr_tap_sequencer

Upstream controller for the NLFSR period tester. Enumerates every unordered pair of nonlinear tap indices (a, b), 1 ≤ a < b ≤ SIZE-1, for one fixed linear coefficient vector. For each pair it resets and loads the tester, waits for its `found`/`failure` verdict, and queues each maximal-period hit into a small result FIFO drained by a valid/ready consumer. It sits between the host/search control and one tester instance, driving the tester's `res`, `ena`, `take_coef`, `coef` and `co_buf_lin` inputs.

## Interface
- `SIZE`, 24: register length of the tester; tap indices range 1..SIZE-1.
- `BYTES`, 4: linear coefficient vector occupies bits [BYTES*8-1:1].
- `FIFO_DEPTH`, 4: result FIFO entries, power of two.
- `WATCHDOG`, (2**SIZE)+7: RUN-state cycle limit (36-bit) before a forced failure.

- `clk` in 1: single clock; all logic on rising edge.
- `res` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a sweep, ignored unless IDLE or DONE.
- `lin_coef` in BYTES*8-1 (bits [BYTES*8-1:1]): linear coefficients, sampled on accepted `start`.
- `tst_res`, `tst_ena`, `take_coef` out 1 each; `coef` out 8: tester control.
- `co_buf_lin` out BYTES*8-1: registered copy of `lin_coef`, stable for the whole sweep.
- `tst_ready`, `tst_found`, `tst_failure` in 1 each: tester status.
- `res_valid` out 1, `res_ready` in 1, `res_taps` out 16 ({3'b0,b},{3'b0,a}): result stream.
- `busy` out 1: high from accepted `start` until DONE. `done` out 1: high in DONE.
- `hit_count`, `timeout_count` out 16 each: per-sweep counters.

## Operation
- Reset: state IDLE; `tst_res`=1, all other outputs 0; FIFO emptied; counters 0; a=1, b=2.
- States: IDLE → CLEAR → LOAD1 → LOAD2 → RUN → (PUSH) → NEXT → CLEAR … → DONE.
- IDLE/DONE: `tst_ena`=0, `tst_res`=1. `start` latches `lin_coef`, clears counters and sets a=1, b=2, then → CLEAR. FIFO contents are preserved across sweeps.
- CLEAR, one cycle: `tst_res`=1, `tst_ena`=0 → LOAD1.
- LOAD1: `tst_ena`=1, `take_coef`=1, `coef`=a → LOAD2.
- LOAD2: `tst_ena`=1, `take_coef`=1, `coef`=b → RUN.
- RUN: `tst_ena`=1, `take_coef`=0; wait-counter increments each cycle.
  - `tst_found` → PUSH.
  - `tst_failure` → NEXT. If `tst_found` and `tst_failure` are both set, `found` wins.
  - Wait-counter = WATCHDOG → NEXT and `timeout_count`+1.
  - If `tst_ready` is still 0 on the first RUN cycle, this counts as a timeout immediately.
- PUSH: `tst_ena`=0 (tester frozen, verdict sticky). When the FIFO is not full, write {b,a}, `hit_count`+1 → NEXT. Stall while full.
- NEXT: `tst_ena`=0. If b<SIZE-1, then b+1. Otherwise, if a<SIZE-2, then a+1 and b=a+2. Otherwise → DONE. Non-DONE exits → CLEAR.
- Pair count per sweep is (SIZE-1)(SIZE-2)/2 (253 for SIZE=24).
- `hit_count` and `timeout_count` saturate at 16'hFFFF.
- FIFO read: `res_valid` means not empty; a pop occurs when `res_valid`&&`res_ready`. A simultaneous push and pop on a full FIFO is allowed.
- `res` mid-sweep aborts to IDLE; the FIFO and counters are cleared.

## Timing
- `start` to first `take_coef`: 2 cycles (CLEAR, LOAD1).
- Verdict to next candidate's LOAD1 is 2 cycles for failure (NEXT, CLEAR) and 3 cycles for found with a non-full FIFO.
- `res_taps` is registered FIFO head data; it is valid the same cycle as `res_valid`, with no combinational path from `res_ready` to `res_taps`.
- Pushed data is visible on `res_valid` the cycle after PUSH.
- `coef` and `take_coef` are registered outputs.

## Structure
- Shared package `nlfsr_pkg` holds:
  - the state enum;
  - the tap-pair packing helper and the pair-count function;
  - `COEF_W`=8, `IDX_W`=5.
- One sub-module, `nlfsr_result_fifo`: synchronous FIFO, width 16, depth FIFO_DEPTH, with full, empty and registered read data. It is reset by `res`.

## Test plan
- SIZE=4 with a behavioural tester model where all verdicts fail. `start` → `coef` sequence 1,2 / 1,3 / 2,3. DONE after 3 candidates, `hit_count`=0, `res_valid` never asserted.
- SIZE=4, model reports found for (1,3) only. One FIFO entry with `res_taps`=16'h0301, `hit_count`=1.
- Model reports found for every pair, FIFO_DEPTH=2, `res_ready`=0. The FSM stalls in PUSH at the 3rd hit. Raising `res_ready` drains 0201, 0301, 0302 in order.
- Model never asserts a verdict, WATCHDOG=20. Each candidate spends exactly 20 RUN cycles, and `timeout_count`=3 at DONE.
- Model asserts `tst_found` and `tst_failure` in the same cycle. Result: PUSH taken, hit recorded.
- Assert `res` during RUN of the 2nd candidate. Next cycle: IDLE, `tst_res`=1, `res_valid`=0, counters 0. A new `start` restarts at (1,2).
